// File: rtl/irb_pkg.sv
// irb_pkg: shared constants and types for the IRB result-buffer stage.
//   IRB_DW/IRB_AW  default pixel and address widths
//   IRB_DEPTH      frame size in pixels
//   IRB_CKW        checksum width (pixel width + address width)
//   irb_state_e    capture/stream FSM states
package irb_pkg;

    localparam int unsigned IRB_DW    = 8;
    localparam int unsigned IRB_AW    = 6;
    localparam int unsigned IRB_DEPTH = 64;
    localparam int unsigned IRB_CKW   = IRB_DW + IRB_AW;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        PRIME   = 2'd1,
        STREAM  = 2'd2,
        WAIT    = 2'd3
    } irb_state_e;

endpackage

// File: rtl/irb_if.sv
// irb_if: LCD-controller write port, done level and the replay pixel stream.
//   IRB_RW/IRB_A/IRB_D  controller write port (IRB_RW low = write)
//   lcd_done            controller frame-complete level
//   pix_valid/pix_ready valid/ready handshake of the replay stream
//   pix_data/pix_addr   streamed pixel and its raster index
//   pix_last            high with the final pixel of the frame
// master: controller + downstream consumer side; slave: irb_capture.
interface irb_if
    import irb_pkg::*;
#(
    parameter int unsigned DW = IRB_DW,
    parameter int unsigned AW = IRB_AW
);

    logic          IRB_RW;
    logic [AW-1:0] IRB_A;
    logic [DW-1:0] IRB_D;
    logic          lcd_done;
    logic          pix_ready;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic [AW-1:0] pix_addr;
    logic          pix_last;

    modport master (
        output IRB_RW, IRB_A, IRB_D, lcd_done, pix_ready,
        input  pix_valid, pix_data, pix_addr, pix_last
    );

    modport slave (
        input  IRB_RW, IRB_A, IRB_D, lcd_done, pix_ready,
        output pix_valid, pix_data, pix_addr, pix_last
    );

endinterface

// File: rtl/irb_mem.sv
// irb_mem: 2**AW x DW frame store, synchronous write, asynchronous read.
//   clk          write clock
//   we/waddr/wdata  write port, captured on the rising edge
//   raddr/rdata  combinational read port
// Contents are deliberately not reset.
module irb_mem
    import irb_pkg::*;
#(
    parameter int unsigned DW = IRB_DW,
    parameter int unsigned AW = IRB_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/irb_capture.sv
// irb_capture: captures the frame written by the LCD controller and replays
// it in raster order over a valid/ready stream once lcd_done rises.
//   clk, reset    rising-edge clock, synchronous active-high reset
//   bus           irb_if.slave: write port, lcd_done, pixel stream
//   frame_err     sticky: frame incomplete at done, or write during stream
//   wr_count      distinct addresses written this frame (0..2**AW)
//   stream_done   one-cycle pulse after the final handshake
//   checksum      (IRB_CHECKSUM_EN only) sum of the streamed pixels
// Optional feature macro: IRB_CHECKSUM_EN.
module irb_capture
    import irb_pkg::*;
#(
    parameter int unsigned DW = IRB_DW,
    parameter int unsigned AW = IRB_AW
) (
    input  logic          clk,
    input  logic          reset,
    irb_if.slave          bus,
    output logic          frame_err,
    output logic [AW:0]   wr_count,
    output logic          stream_done
`ifdef IRB_CHECKSUM_EN
    ,
    output logic [DW+AW-1:0] checksum
`endif
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    irb_state_e       state_q, state_d;
    logic [DEPTH-1:0] written_q, written_d;
    logic [AW:0]      wr_count_q, wr_count_d;
    logic             pix_valid_q, pix_valid_d;
    logic [DW-1:0]    pix_data_q, pix_data_d;
    logic [AW-1:0]    pix_addr_q, pix_addr_d;
    logic             frame_err_q, frame_err_d;
    logic             stream_done_q, stream_done_d;

`ifdef IRB_CHECKSUM_EN
    localparam int unsigned CKW = DW + AW;
    logic [CKW-1:0]   checksum_q, checksum_d;
`endif

    logic             wr_req_c;
    logic             new_addr_c;
    logic [AW:0]      cnt_inc_c;
    logic             hs_c;
    logic             mem_we_c;
    logic [AW-1:0]    rd_addr_c;
    logic [DW-1:0]    rd_data_c;

    irb_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (bus.IRB_A),
        .wdata (bus.IRB_D),
        .raddr (rd_addr_c),
        .rdata (rd_data_c)
    );

    // Write bookkeeping: count only first-time addresses, including the
    // write that may coincide with lcd_done.
    assign wr_req_c   = ~bus.IRB_RW;
    assign new_addr_c = wr_req_c & ~written_q[bus.IRB_A];
    assign cnt_inc_c  = wr_count_q + (AW+1)'(new_addr_c);
    assign hs_c       = pix_valid_q & bus.pix_ready;

    // Next-state and datapath
    always_comb begin
        state_d       = state_q;
        written_d     = written_q;
        wr_count_d    = wr_count_q;
        pix_valid_d   = pix_valid_q;
        pix_data_d    = pix_data_q;
        pix_addr_d    = pix_addr_q;
        frame_err_d   = frame_err_q;
        stream_done_d = 1'b0;
        mem_we_c      = 1'b0;
        rd_addr_c     = pix_addr_q + AW'(1);
`ifdef IRB_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif

        case (state_q)
            CAPTURE: begin
                mem_we_c = wr_req_c;
                if (wr_req_c) begin
                    written_d[bus.IRB_A] = 1'b1;
                    wr_count_d           = cnt_inc_c;
                end
                if (bus.lcd_done) begin
                    state_d = PRIME;
                    if (cnt_inc_c < FULL_CNT) begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            PRIME: begin
                rd_addr_c   = '0;
                pix_data_d  = rd_data_c;
                pix_addr_d  = '0;
                pix_valid_d = 1'b1;
`ifdef IRB_CHECKSUM_EN
                checksum_d  = '0;
`endif
                state_d     = STREAM;
            end

            STREAM: begin
                // Writes are dropped while replaying; they only flag the frame.
                if (wr_req_c) begin
                    frame_err_d = 1'b1;
                end
                if (hs_c) begin
`ifdef IRB_CHECKSUM_EN
                    checksum_d = checksum_q + CKW'(pix_data_q);
`endif
                    if (pix_addr_q == LAST_ADDR) begin
                        pix_valid_d   = 1'b0;
                        stream_done_d = 1'b1;
                        state_d       = WAIT;
                    end else begin
                        pix_addr_d = rd_addr_c;
                        pix_data_d = rd_data_c;
                    end
                end
            end

            WAIT: begin
                if (!bus.lcd_done) begin
                    written_d  = '0;
                    wr_count_d = '0;
                    state_d    = CAPTURE;
                end
            end

            default: begin
                state_d = CAPTURE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CAPTURE;
            written_q     <= '0;
            wr_count_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_addr_q    <= '0;
            frame_err_q   <= 1'b0;
            stream_done_q <= 1'b0;
`ifdef IRB_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            written_q     <= written_d;
            wr_count_q    <= wr_count_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_addr_q    <= pix_addr_d;
            frame_err_q   <= frame_err_d;
            stream_done_q <= stream_done_d;
`ifdef IRB_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_addr  = pix_addr_q;
    assign bus.pix_last  = pix_valid_q & (pix_addr_q == LAST_ADDR);
    assign frame_err     = frame_err_q;
    assign wr_count      = wr_count_q;
    assign stream_done   = stream_done_q;
`ifdef IRB_CHECKSUM_EN
    assign checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_irb_capture.sv
// tb_irb_capture: self-checking bench for irb_capture. A frame-level model
// (pixel array, written set, sticky error flag) predicts the capture count,
// the error flag and the replayed pixel sequence.
module tb_irb_capture;
    import irb_pkg::*;

    localparam int NPIX = IRB_DEPTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    irb_if bus ();
    logic              frame_err;
    logic [IRB_AW:0]   wr_count;
    logic              stream_done;
`ifdef IRB_CHECKSUM_EN
    logic [IRB_CKW-1:0] checksum;
`endif

    irb_capture dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .frame_err   (frame_err),
        .wr_count    (wr_count),
        .stream_done (stream_done)
`ifdef IRB_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model
    logic [7:0] ref_mem [NPIX];
    bit         ref_written [NPIX];
    bit         ref_err;

    logic [7:0] got_data [$];
    logic [5:0] got_addr [$];
    bit         got_last [$];
    int         done_cyc;
    int         first_valid_cyc;
    int         last_hs_cyc;
    bit         aborted;

    typedef struct {
        bit         we;
        int         a;
        logic [7:0] d;
        int         exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int ref_count();
        int n = 0;
        for (int i = 0; i < NPIX; i++) n += int'(ref_written[i]);
        return n;
    endfunction

    function automatic int ref_sum();
        int s = 0;
        for (int i = 0; i < NPIX; i++) s += int'(ref_mem[i]);
        return s;
    endfunction

    task automatic clear_written();
        for (int i = 0; i < NPIX; i++) ref_written[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.IRB_RW = 1'b0;
        bus.IRB_A  = 6'(a);
        bus.IRB_D  = d;
        tick();
        bus.IRB_RW = 1'b1;
        ref_mem[a]     = d;
        ref_written[a] = 1'b1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.IRB_RW   = 1'b1;
        bus.lcd_done = 1'b0;
        bus.pix_ready = 1'b0;
        tick();
        reset = 1'b0;
        clear_written();
        ref_err = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) wr(i, 8'($urandom));
    endtask

    // Leave WAIT and verify the per-frame bookkeeping restarts.
    task automatic finish_wait();
        bus.lcd_done  = 1'b0;
        bus.pix_ready = 1'b0;
        tick();
        check("wait_exit_wr_count", 64'(wr_count), 64'd0);
        check("wait_exit_stream_done", 64'(stream_done), 64'd0);
        check("wait_exit_valid", 64'(bus.pix_valid), 64'd0);
        clear_written();
    endtask

    // Raise done (optionally with a write in that cycle), then replay.
    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready
    // and random lcd_done toggling during the stream.
    task automatic stream_frame(input int mode, input int done_wr_addr, input int inject_cyc,
                                input int abort_at, input bit keep_done);
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [5:0] prev_addr;
        bit         rdy;
        logic [7:0] dwd;
        got_data.delete();
        got_addr.delete();
        got_last.delete();
        done_cyc        = -1;
        first_valid_cyc = -1;
        last_hs_cyc     = -1;
        aborted         = 1'b0;
        prev_stall      = 1'b0;
        prev_data       = '0;
        prev_addr       = '0;

        bus.lcd_done  = 1'b1;
        bus.pix_ready = 1'b0;
        if (done_wr_addr >= 0) begin
            dwd        = 8'($urandom);
            bus.IRB_RW = 1'b0;
            bus.IRB_A  = 6'(done_wr_addr);
            bus.IRB_D  = dwd;
            ref_mem[done_wr_addr]     = dwd;
            ref_written[done_wr_addr] = 1'b1;
        end
        tick();
        bus.IRB_RW = 1'b1;
        if (ref_count() < NPIX) ref_err = 1'b1;
        check("prime_valid", 64'(bus.pix_valid), 64'd0);
        check("prime_wr_count", 64'(wr_count), 64'(ref_count()));
        check("prime_frame_err", 64'(frame_err), 64'(ref_err));
        bus.lcd_done = keep_done;

        for (int cyc = 0; cyc < 800; cyc++) begin
            tick();
            bus.IRB_RW = 1'b1;
            if (prev_stall) begin
                check("hold_valid", 64'(bus.pix_valid), 64'd1);
                check("hold_data", 64'(bus.pix_data), 64'(prev_data));
                check("hold_addr", 64'(bus.pix_addr), 64'(prev_addr));
            end
            if (bus.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stream_done) begin
                done_cyc = cyc;
                check("done_valid_low", 64'(bus.pix_valid), 64'd0);
                check("end_frame_err", 64'(frame_err), 64'(ref_err));
`ifdef IRB_CHECKSUM_EN
                check("checksum", 64'(checksum), 64'(ref_sum()));
`endif
                bus.lcd_done  = keep_done;
                bus.pix_ready = 1'b0;
                break;
            end
            if (abort_at >= 0 && bus.pix_valid && int'(bus.pix_addr) == abort_at) begin
                reset        = 1'b1;
                aborted      = 1'b1;
                bus.lcd_done = 1'b0;
                break;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = ($urandom_range(3) != 0);
            endcase
            if (mode == 2) bus.lcd_done = 1'($urandom_range(1));
            bus.pix_ready = rdy;
            if (cyc == inject_cyc) begin
                bus.IRB_RW = 1'b0;
                bus.IRB_A  = 6'($urandom);
                bus.IRB_D  = 8'($urandom);
                ref_err    = 1'b1;
            end
            if (bus.pix_valid && rdy) begin
                got_data.push_back(bus.pix_data);
                got_addr.push_back(bus.pix_addr);
                got_last.push_back(bus.pix_last);
                last_hs_cyc = cyc;
            end
            prev_stall = bus.pix_valid && !rdy;
            prev_data  = bus.pix_data;
            prev_addr  = bus.pix_addr;
        end
        bus.IRB_RW = 1'b1;

        if (!aborted) begin
            check("stream_done_seen", 64'(done_cyc >= 0), 64'd1);
            check("first_valid_cyc", 64'(first_valid_cyc), 64'd0);
            check("pix_count", 64'(got_data.size()), 64'(NPIX));
            check("done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));
            for (int i = 0; i < got_data.size(); i++) begin
                check($sformatf("pix_data[%0d]", i), 64'(got_data[i]), 64'(ref_mem[i]));
                check($sformatf("pix_addr[%0d]", i), 64'(got_addr[i]), 64'(i));
                check($sformatf("pix_last[%0d]", i), 64'(got_last[i]), 64'(i == NPIX - 1));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        vecs[0] = '{1'b1, 5,  8'h11, 1};
        vecs[1] = '{1'b1, 5,  8'hAA, 1};
        vecs[2] = '{1'b0, 0,  8'h00, 1};
        vecs[3] = '{1'b1, 0,  8'h3C, 2};
        vecs[4] = '{1'b1, 63, 8'hC3, 3};
        vecs[5] = '{1'b1, 0,  8'h5A, 3};
        vecs[6] = '{1'b1, 62, 8'h01, 4};
        vecs[7] = '{1'b0, 0,  8'h00, 4};

        bus.IRB_RW    = 1'b1;
        bus.IRB_A     = '0;
        bus.IRB_D     = '0;
        bus.lcd_done  = 1'b0;
        bus.pix_ready = 1'b0;
        ref_err       = 1'b0;
        clear_written();

        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_pix_valid", 64'(bus.pix_valid), 64'd0);
        check("rst_pix_data", 64'(bus.pix_data), 64'd0);
        check("rst_pix_addr", 64'(bus.pix_addr), 64'd0);
        check("rst_pix_last", 64'(bus.pix_last), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_stream_done", 64'(stream_done), 64'd0);
`ifdef IRB_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif
        reset = 1'b0;

        // Ramp frame, ready held high, lcd_done held through the stream
        for (int i = 0; i < NPIX; i++) wr(i, 8'(i));
        stream_frame(0, -1, -1, -1, 1'b1);
        check("ramp_done_cycle", 64'(done_cyc), 64'd64);
        check("ramp_frame_err", 64'(frame_err), 64'd0);
`ifdef IRB_CHECKSUM_EN
        check("ramp_checksum", 64'(checksum), 64'd2016);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wait_hold_wr_count", 64'(wr_count), 64'd64);
            check("wait_hold_pulse", 64'(stream_done), 64'd0);
        end
        finish_wait();

        // Same frame with ready stalling
        for (int i = 0; i < NPIX; i++) wr(i, 8'(i));
        stream_frame(1, -1, -1, -1, 1'b0);
        finish_wait();

        // Incomplete frame: 0..62 only
        for (int i = 0; i < NPIX - 1; i++) wr(i, 8'(i * 5 + 1));
        stream_frame(0, -1, -1, -1, 1'b0);
        check("partial_frame_err", 64'(frame_err), 64'd1);
        finish_wait();
        check("partial_err_sticky", 64'(frame_err), 64'd1);
        do_reset();
        check("reset_clears_err", 64'(frame_err), 64'd0);

        // Final address arrives in the same cycle as done
        for (int i = 0; i < NPIX - 1; i++) wr(i, 8'($urandom));
        stream_frame(2, NPIX - 1, -1, -1, 1'b0);
        check("done_write_no_err", 64'(frame_err), 64'd0);
        finish_wait();

        // Table: duplicate-address counting
        do_reset();
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].we) wr(vecs[v].a, vecs[v].d);
            else tick();
            check($sformatf("vec%0d_wr_count", v), 64'(wr_count), 64'(vecs[v].exp_cnt));
        end
        for (int i = 1; i < 62; i++) if (i != 5) wr(i, 8'($urandom));
        check("vec_full_count", 64'(wr_count), 64'd64);
        stream_frame(0, -1, -1, -1, 1'b0);
        check("vec_pix5", 64'(got_data[5]), 64'hAA);
        check("vec_pix0", 64'(got_data[0]), 64'h5A);
        check("vec_frame_err", 64'(frame_err), 64'd0);
        finish_wait();

        // Write during stream is dropped and flagged
        do_reset();
        fill_random();
        stream_frame(0, -1, 10, -1, 1'b0);
        check("stream_write_err", 64'(frame_err), 64'd1);
        finish_wait();

        // Reset at pixel 30, then a clean frame
        fill_random();
        stream_frame(0, -1, 10, 30, 1'b0);
        check("abort_reached", 64'(aborted), 64'd1);
        tick();
        check("abort_valid", 64'(bus.pix_valid), 64'd0);
        check("abort_wr_count", 64'(wr_count), 64'd0);
        check("abort_frame_err", 64'(frame_err), 64'd0);
        check("abort_pix_addr", 64'(bus.pix_addr), 64'd0);
        check("abort_stream_done", 64'(stream_done), 64'd0);
        reset = 1'b0;
        clear_written();
        ref_err = 1'b0;
        fill_random();
        stream_frame(2, -1, -1, -1, 1'b0);
        finish_wait();

        // Randomized frames against the model
        do_reset();
        for (int f = 0; f < 6; f++) begin
            if (f % 2 == 0) begin
                for (int i = 0; i < NPIX; i++) wr((i * 37) % NPIX, 8'($urandom));
            end
            repeat ($urandom_range(10, 40)) begin
                if ($urandom_range(3) == 0) tick();
                else wr(int'($urandom_range(NPIX - 1)), 8'($urandom));
            end
            check("rand_wr_count", 64'(wr_count), 64'(ref_count()));
            stream_frame(2, ($urandom_range(1) != 0) ? int'($urandom_range(NPIX - 1)) : -1,
                         (f % 3 == 0) ? int'($urandom_range(1, 20)) : -1, -1, 1'b0);
            finish_wait();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
